fa16b_rev_seq: RTL and testbench
================================

Name: fa16b_rev_seq

Overview:
- Phase sequencer for the 16-bit reversible dual-rail adder macro.
- Accepts one operand set per transaction over a valid/ready handshake.
- Drives the adder's forward true/complement rails, samples the sum rails, then senses the backward (restoration) rails and checks they reproduce operand A and carry-in.
- Returns all rails to null and hands the result to the requester over a second valid/ready handshake.

Parameters:
- WIDTH, 16, datapath width; matches the adder macro.
- SETTLE_CYCLES, 4, cycles the forward rails are held before the sum is sampled (0 treated as 1).
- UNDO_CYCLES, 4, cycles the backward phase lasts before the restoration rails are sampled (0 treated as 1).
- NULL_CYCLES, 2, cycles all driven rails are held at null (both low) before the result is presented (0 treated as 1).

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  sequencer can accept
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry in
- a_f / a_not_f  out  WIDTH  forward A true/complement rails
- b / b_not  out  WIDTH  B rails
- c0_f / c0_f_not  out  1  forward carry rails
- z / z_not  out  1  zero ancilla rails
- s / s_not  in  WIDTH  sum rails from the adder
- c15 / c15_not  in  1  carry-out rails
- a_b / a_not_b  in  WIDTH  backward A rails
- c0_b / c0_not_b  in  1  backward carry rails
- res_valid  out  1  result available
- res_ready  in  1  requester accepts result
- res_sum  out  WIDTH  sampled sum (true rail)
- res_cout  out  1  sampled carry-out
- res_err  out  2  bit0 = sum rail fault; bit1 = restoration mismatch

Behaviour:
- Dual-rail encoding:
  - Null is both rails 0.
  - Valid is complementary rails.
  - Both rails 1 is illegal and is never driven.
- Reset (async) forces:
  - state IDLE
  - all driven rails 0
  - res_valid=0, res_sum=0, res_cout=0, res_err=0
  - in_ready=0 while rst is high
- Reset mid-transaction drops all rails to null in the same cycle; the transaction is discarded with no result.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch A, B, cin and go to FWD.
  - FWD: lasts SETTLE_CYCLES. Drives a_f=A, a_not_f=~A, b=B, b_not=~B, c0_f=cin, c0_f_not=~cin, z=0, z_not=1. At the edge ending the last FWD cycle, capture s, s_not, c15, c15_not; go to BWD.
  - BWD: lasts UNDO_CYCLES. Forward rails stay driven. At the edge ending the last BWD cycle, capture a_b, a_not_b, c0_b, c0_not_b; go to NULL.
  - NULL: lasts NULL_CYCLES. All driven rails 0. Go to DONE; res_err is computed on entry.
  - DONE: res_valid=1; outputs stable until res_ready. On res_valid&res_ready go to IDLE. res_valid drops on the next cycle.
- in_ready=0 in every state except IDLE; there is no overlap of transactions.
- Latency: res_valid first asserts SETTLE_CYCLES+UNDO_CYCLES+NULL_CYCLES+1 cycles after the accept edge (11 with defaults).
- res_err computation:
  - bit0 is set if any s[i]==s_not[i], or c15==c15_not.
  - bit1 is set if a_b!=A, or a_not_b!=~A, or c0_b!=cin, or c0_not_b!=~cin.
- res_sum and res_cout are the captured true rails and are reported even when res_err is set.
- res_sum, res_cout and res_err are held after handshake until the next capture.
- Phase counter width is clog2 of the max of the three parameters, plus 1. The counter reloads on every phase entry.

Test Plan:
- A=0x1234, B=0x4321, cin=0, ideal adder model → on cycle 11 after accept: res_sum=0x5555, res_cout=0, res_err=00. Rails are complementary during cycles 1–8 and null during cycles 9–10.
- A=0xFFFF, B=0x0001, cin=1 → res_sum=0x0001, res_cout=1, res_err=00.
- Hold res_ready=0 for 5 cycles after res_valid while in_valid=1 → outputs stable, in_ready=0, no second accept. Accept resumes on the cycle after the handshake.
- Model drives s[7]=s_not[7]=1 → res_err=01.
- Model flips backward rail bit 3 (a_b[3]=~A[3], a_not_b[3]=A[3]) → res_err=10.
- Assert rst during BWD → all rails 0 immediately, res_valid=0. After deassert, in_ready=1 and a fresh transaction completes with correct values.

Source files
------------

// File: rtl/fa16b_rev_seq.sv
// ---------------------------------------------------------------------------
// fa16b_rev_seq
//   Phase sequencer for the 16-bit reversible dual-rail adder macro.
//   A transaction runs IDLE -> FWD -> BWD -> NULL -> DONE -> IDLE:
//     FWD  : forward rails driven, sum/carry-out rails sampled at the end
//     BWD  : forward rails held, restoration rails sampled at the end
//     NULL : every driven rail held at null (both low)
//     DONE : result presented until the requester takes it
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        operand handshake (in_a, in_b, in_cin)
//   a_f/a_not_f, b/b_not     forward operand rails to the adder
//   c0_f/c0_f_not, z/z_not   forward carry-in and zero-ancilla rails
//   s/s_not, c15/c15_not     sum and carry-out rails from the adder
//   a_b/a_not_b, c0_b/...    backward (restoration) rails from the adder
//   res_valid/res_ready      result handshake (res_sum, res_cout, res_err)
//   res_err                  bit0 sum rail fault, bit1 restoration mismatch
// ---------------------------------------------------------------------------
module fa16b_rev_seq #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned UNDO_CYCLES   = 4,
    parameter int unsigned NULL_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] a_f,
    output logic [WIDTH-1:0] a_not_f,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] b_not,
    output logic             c0_f,
    output logic             c0_f_not,
    output logic             z,
    output logic             z_not,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] s_not,
    input  logic             c15,
    input  logic             c15_not,
    input  logic [WIDTH-1:0] a_b,
    input  logic [WIDTH-1:0] a_not_b,
    input  logic             c0_b,
    input  logic             c0_not_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic [1:0]       res_err
);

    // A zero-length phase is stretched to one cycle.
    localparam int unsigned SettleEff = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned UndoEff   = (UNDO_CYCLES == 0) ? 1 : UNDO_CYCLES;
    localparam int unsigned NullEff   = (NULL_CYCLES == 0) ? 1 : NULL_CYCLES;
    localparam int unsigned MaxTmp    = (SettleEff > UndoEff) ? SettleEff : UndoEff;
    localparam int unsigned MaxCyc    = (MaxTmp > NullEff) ? MaxTmp : NullEff;
    localparam int unsigned CntW      = $clog2(MaxCyc) + 1;

    // Counter is loaded with (length - 1) on phase entry; phase ends at zero.
    localparam logic [CntW-1:0] SettleLoad = CntW'(SettleEff - 1);
    localparam logic [CntW-1:0] UndoLoad   = CntW'(UndoEff - 1);
    localparam logic [CntW-1:0] NullLoad   = CntW'(NullEff - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFwd,
        StBwd,
        StNull,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              cin_q, cin_d;
    logic [WIDTH-1:0]  s_cap_q, s_cap_d;
    logic [WIDTH-1:0]  s_not_cap_q, s_not_cap_d;
    logic              c15_cap_q, c15_cap_d;
    logic              c15_not_cap_q, c15_not_cap_d;
    logic [WIDTH-1:0]  ab_cap_q, ab_cap_d;
    logic [WIDTH-1:0]  anb_cap_q, anb_cap_d;
    logic              c0b_cap_q, c0b_cap_d;
    logic              c0nb_cap_q, c0nb_cap_d;
    logic              res_valid_q, res_valid_d;
    logic [WIDTH-1:0]  res_sum_q, res_sum_d;
    logic              res_cout_q, res_cout_d;
    logic [1:0]        res_err_q, res_err_d;

    logic              drive_fwd;
    logic              sum_fault;
    logic              restore_mismatch;

    // A rail pair is faulty when both rails agree (null or illegal).
    assign sum_fault = (|(~(s_cap_q ^ s_not_cap_q))) | (c15_cap_q == c15_not_cap_q);

    assign restore_mismatch = (ab_cap_q != a_q) | (anb_cap_q != ~a_q) |
                              (c0b_cap_q != cin_q) | (c0nb_cap_q != ~cin_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        cin_d         = cin_q;
        s_cap_d       = s_cap_q;
        s_not_cap_d   = s_not_cap_q;
        c15_cap_d     = c15_cap_q;
        c15_not_cap_d = c15_not_cap_q;
        ab_cap_d      = ab_cap_q;
        anb_cap_d     = anb_cap_q;
        c0b_cap_d     = c0b_cap_q;
        c0nb_cap_d    = c0nb_cap_q;
        res_valid_d   = res_valid_q;
        res_sum_d     = res_sum_q;
        res_cout_d    = res_cout_q;
        res_err_d     = res_err_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    cin_d   = in_cin;
                    cnt_d   = SettleLoad;
                    state_d = StFwd;
                end
            end
            StFwd: begin
                if (cnt_q == '0) begin
                    s_cap_d       = s;
                    s_not_cap_d   = s_not;
                    c15_cap_d     = c15;
                    c15_not_cap_d = c15_not;
                    cnt_d         = UndoLoad;
                    state_d       = StBwd;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StBwd: begin
                if (cnt_q == '0) begin
                    ab_cap_d   = a_b;
                    anb_cap_d  = a_not_b;
                    c0b_cap_d  = c0_b;
                    c0nb_cap_d = c0_not_b;
                    cnt_d      = NullLoad;
                    state_d    = StNull;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StNull: begin
                if (cnt_q == '0) begin
                    res_valid_d = 1'b1;
                    res_sum_d   = s_cap_q;
                    res_cout_d  = c15_cap_q;
                    res_err_d   = {restore_mismatch, sum_fault};
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cin_q         <= 1'b0;
            s_cap_q       <= '0;
            s_not_cap_q   <= '0;
            c15_cap_q     <= 1'b0;
            c15_not_cap_q <= 1'b0;
            ab_cap_q      <= '0;
            anb_cap_q     <= '0;
            c0b_cap_q     <= 1'b0;
            c0nb_cap_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_sum_q     <= '0;
            res_cout_q    <= 1'b0;
            res_err_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cin_q         <= cin_d;
            s_cap_q       <= s_cap_d;
            s_not_cap_q   <= s_not_cap_d;
            c15_cap_q     <= c15_cap_d;
            c15_not_cap_q <= c15_not_cap_d;
            ab_cap_q      <= ab_cap_d;
            anb_cap_q     <= anb_cap_d;
            c0b_cap_q     <= c0b_cap_d;
            c0nb_cap_q    <= c0nb_cap_d;
            res_valid_q   <= res_valid_d;
            res_sum_q     <= res_sum_d;
            res_cout_q    <= res_cout_d;
            res_err_q     <= res_err_d;
        end
    end

    // Rails decode straight from the state register so an asynchronous reset
    // drops them to null without waiting for a clock edge.
    assign drive_fwd = (state_q == StFwd) || (state_q == StBwd);

    assign a_f      = drive_fwd ? a_q : '0;
    assign a_not_f  = drive_fwd ? ~a_q : '0;
    assign b        = drive_fwd ? b_q : '0;
    assign b_not    = drive_fwd ? ~b_q : '0;
    assign c0_f     = drive_fwd & cin_q;
    assign c0_f_not = drive_fwd & ~cin_q;
    assign z        = 1'b0;
    assign z_not    = drive_fwd;

    assign in_ready  = (state_q == StIdle) && !rst;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_fa16b_rev_seq.sv
// Directed bench for fa16b_rev_seq with a behavioural dual-rail adder model
// and switchable sum/restoration faults.
module tb_fa16b_rev_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic [15:0] a_f, a_not_f, b, b_not;
    logic        c0_f, c0_f_not, z, z_not;
    logic [15:0] s, s_not;
    logic        c15, c15_not;
    logic [15:0] a_b, a_not_b;
    logic        c0_b, c0_not_b;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_sum;
    logic        res_cout;
    logic [1:0]  res_err;

    logic        fault_s7 = 1'b0;
    logic        fault_b3 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fa16b_rev_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .a_f(a_f), .a_not_f(a_not_f), .b(b), .b_not(b_not),
        .c0_f(c0_f), .c0_f_not(c0_f_not), .z(z), .z_not(z_not),
        .s(s), .s_not(s_not), .c15(c15), .c15_not(c15_not),
        .a_b(a_b), .a_not_b(a_not_b), .c0_b(c0_b), .c0_not_b(c0_not_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_err(res_err)
    );

    // Ideal adder: null in gives null out, valid in gives the true sum.
    logic        fwd_on;
    logic [16:0] sum17;
    always_comb begin
        fwd_on   = c0_f ^ c0_f_not;
        sum17    = {1'b0, a_f} + {1'b0, b} + {16'd0, c0_f};
        s        = fwd_on ? sum17[15:0] : 16'h0000;
        s_not    = fwd_on ? ~sum17[15:0] : 16'h0000;
        c15      = fwd_on & sum17[16];
        c15_not  = fwd_on & ~sum17[16];
        a_b      = a_f;
        a_not_b  = a_not_f;
        c0_b     = c0_f;
        c0_not_b = c0_f_not;
        if (fault_s7 && fwd_on) begin
            s[7]     = 1'b1;
            s_not[7] = 1'b1;
        end
        if (fault_b3 && fwd_on) begin
            a_b[3]     = ~a_f[3];
            a_not_b[3] = a_f[3];
        end
    end

    logic [67:0] rails;
    assign rails = {a_f, a_not_f, b, b_not, c0_f, c0_f_not, z, z_not};

    // Stimulus only: accept, wait (bounded) for the result, take it.
    // lat = cycles from the accept edge to res_valid, 0 on timeout.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] bb, input logic ci,
                           output logic [15:0] sum, output logic co,
                           output logic [1:0] err, output int lat);
        @(negedge clk);
        in_a = a; in_b = bb; in_cin = ci; in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (res_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        sum = res_sum; co = res_cout; err = res_err;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, res_valid, res_sum, res_cout, res_err} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%h co=%b err=%b, want all 0",
                     in_ready, res_valid, res_sum, res_cout, res_err);
        end
        checks++;
        if (rails !== 68'h0) begin
            errors++;
            $display("FAIL reset_rails: got %h, want 0", rails);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, want 1", in_ready);
        end
    endtask

    // Cycle-by-cycle walk of A=0x1234, B=0x4321, cin=0.
    task automatic test_basic();
        logic [67:0] exp_rails;
        @(negedge clk);
        in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: got %b, want 1", in_ready);
        end
        @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            exp_rails = (k <= 8) ? {16'h1234, 16'hEDCB, 16'h4321, 16'hBCDE, 4'b0101} : 68'h0;
            checks++;
            if (k <= 10 && (rails !== exp_rails || res_valid !== 1'b0 || in_ready !== 1'b0))
            begin
                errors++;
                $display("FAIL basic_cycle%0d: got rails=%h vld=%b rdy=%b, want %h 0 0",
                         k, rails, res_valid, in_ready, exp_rails);
            end
            if (k == 11 && {res_valid, res_sum, res_cout, res_err} !== {1'b1, 16'h5555, 3'b000})
            begin
                errors++;
                $display("FAIL basic_result: got vld=%b sum=%h co=%b err=%b, want 1 5555 0 00",
                         res_valid, res_sum, res_cout, res_err);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || res_sum !== 16'h5555) begin
            errors++;
            $display("FAIL basic_handshake: got vld=%b rdy=%b sum=%h, want 0 1 5555",
                     res_valid, in_ready, res_sum);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] sum; logic co; logic [1:0] err; int lat;
        run_txn(16'hFFFF, 16'h0001, 1'b1, sum, co, err, lat);
        checks++;
        if ({sum, co, err} !== {16'h0001, 1'b1, 2'b00} || lat != 11) begin
            errors++;
            $display("FAIL wrap: got sum=%h co=%b err=%b lat=%0d, want 0001 1 00 11",
                     sum, co, err, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        in_a = 16'h00FF; in_b = 16'h0F0F; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Second request held from here on; it must wait for the handshake.
        in_a = 16'h8000; in_b = 16'h8000; in_cin = 1'b0;
        for (int k = 0; k < 40 && !res_valid; k++) begin
            if (in_ready !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL bp_busy_ready: got in_ready=%b mid-transaction, want 0", in_ready);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({res_valid, in_ready, res_sum, res_cout, res_err} !== {2'b10, 16'h100F, 3'b000})
            begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b sum=%h co=%b err=%b, want 1 0 100f 0 00",
                         k, res_valid, in_ready, res_sum, res_cout, res_err);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b, want 0 1", res_valid, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (a_f !== 16'h8000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: got a_f=%h rdy=%b, want 8000 0", a_f, in_ready);
        end
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (res_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if ({res_sum, res_cout, res_err} !== {16'h0000, 1'b1, 2'b00} || lat != 11) begin
            errors++;
            $display("FAIL bp_second_result: got sum=%h co=%b err=%b lat=%0d, want 0000 1 00 11",
                     res_sum, res_cout, res_err, lat);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_sum_fault();
        logic [15:0] sum; logic co; logic [1:0] err; int lat;
        fault_s7 = 1'b1;
        run_txn(16'h0101, 16'h0202, 1'b0, sum, co, err, lat);
        fault_s7 = 1'b0;
        checks++;
        if (err !== 2'b01 || co !== 1'b0 || sum !== 16'h0383 || lat != 11) begin
            errors++;
            $display("FAIL sum_fault: got err=%b sum=%h co=%b lat=%0d, want 01 0383 0 11",
                     err, sum, co, lat);
        end
    endtask

    task automatic test_restore_fault();
        logic [15:0] sum; logic co; logic [1:0] err; int lat;
        fault_b3 = 1'b1;
        run_txn(16'hA5A5, 16'h5A5A, 1'b1, sum, co, err, lat);
        fault_b3 = 1'b0;
        checks++;
        if ({sum, co, err} !== {16'h0000, 1'b1, 2'b10} || lat != 11) begin
            errors++;
            $display("FAIL restore_fault: got sum=%h co=%b err=%b lat=%0d, want 0000 1 10 11",
                     sum, co, err, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] sum; logic co; logic [1:0] err; int lat;
        @(negedge clk);
        in_a = 16'h3C3C; in_b = 16'h1111; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);  // now in cycle 6, the backward phase
        checks++;
        if (a_f !== 16'h3C3C) begin
            errors++;
            $display("FAIL mid_pre_reset: got a_f=%h, want 3c3c", a_f);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rails !== 68'h0 || res_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got rails=%h vld=%b rdy=%b, want 0 0 0",
                     rails, res_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: got rdy=%b vld=%b, want 1 0", in_ready, res_valid);
        end
        run_txn(16'h7FFF, 16'h0001, 1'b0, sum, co, err, lat);
        checks++;
        if ({sum, co, err} !== {16'h8000, 1'b0, 2'b00} || lat != 11) begin
            errors++;
            $display("FAIL mid_fresh: got sum=%h co=%b err=%b lat=%0d, want 8000 0 00 11",
                     sum, co, err, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_sum_fault();
        test_restore_fault();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, want finished");
        $fatal(1);
    end

endmodule
